// File: rtl/truth_table_sweeper_if.sv
// Sweeper bus: start request, DUT/golden outputs in, stimulus and status out.
// master = controller/testbench side, slave = truth_table_sweeper.
interface truth_table_sweeper_if #(
   parameter int N_IN  = 3,
   parameter int N_OUT = 2
);
   logic             start;
   logic [N_OUT-1:0] dut_out;
   logic [N_OUT-1:0] exp_out;
   logic [N_IN-1:0]  vec;
   logic             sample;
   logic             busy;
   logic             done;
   logic [N_IN:0]    err_cnt;
   logic             err_flag;
   logic [N_IN-1:0]  first_err;

   modport master (
      output start, dut_out, exp_out,
      input  vec, sample, busy, done,
      input  err_cnt, err_flag, first_err
   );

   modport slave (
      input  start, dut_out, exp_out,
      output vec, sample, busy, done,
      output err_cnt, err_flag, first_err
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2^N_IN vectors (binary or Gray), holds each DWELL cycles and
// compares dut_out to exp_out in the last cycle of each vector.
// Ports: clk_i, reset_i (sync, active-high), bus (slave modport):
//   start, dut_out, exp_out in; vec, sample, busy, done, err_cnt,
//   err_flag, first_err out.
module truth_table_sweeper #(
   parameter int N_IN  = 3,
   parameter int N_OUT = 2,
   parameter int DWELL = 10,
   parameter int GRAY  = 0
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   truth_table_sweeper_if.slave bus
);
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0]   CNT_ONE  = 1;
   localparam logic [N_IN-1:0] IDX_LAST = '1;
   localparam logic [N_IN-1:0] IDX_ONE  = 1;
   localparam logic [N_IN:0]   ERR_ONE  = 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N_IN:0]   err_cnt_q, err_cnt_d;
   logic            err_flag_q, err_flag_d;
   logic [N_IN-1:0] first_q, first_d;

   logic [N_IN-1:0] vec_w;
   logic            sample_w;
   logic            mism_w;

   // idx stays at its last value in DONE, so vec holds the final vector
   assign vec_w    = (GRAY != 0) ? (idx_q ^ (idx_q >> 1)) : idx_q;
   assign sample_w = (state_q == S_RUN) && (cnt_q == CNT_LAST);
   assign mism_w   = (bus.dut_out != bus.exp_out);

   assign bus.vec       = vec_w;
   assign bus.sample    = sample_w;
   assign bus.busy      = (state_q == S_RUN);
   assign bus.done      = (state_q == S_DONE);
   assign bus.err_cnt   = err_cnt_q;
   assign bus.err_flag  = err_flag_q;
   assign bus.first_err = first_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      err_cnt_d  = err_cnt_q;
      err_flag_d = err_flag_q;
      first_d    = first_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d    = S_RUN;
               idx_d      = '0;
               cnt_d      = '0;
               err_cnt_d  = '0;
               err_flag_d = 1'b0;
               first_d    = '0;
            end
         end
         S_RUN: begin
            if (sample_w) begin
               if (mism_w) begin
                  err_cnt_d = err_cnt_q + ERR_ONE;
                  if (!err_flag_q) begin
                     err_flag_d = 1'b1;
                     first_d    = vec_w;
                  end
               end
               if (idx_q != IDX_LAST) begin
                  idx_d = idx_q + IDX_ONE;
                  cnt_d = '0;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         err_cnt_q  <= '0;
         err_flag_q <= 1'b0;
         first_q    <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         err_cnt_q  <= err_cnt_d;
         err_flag_q <= err_flag_d;
         first_q    <= first_d;
      end
   end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: default, Gray/DWELL=2 and
// DWELL=1/N_IN=4 instances driven from one directed sequence.
module tb_truth_table_sweeper;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   truth_table_sweeper_if #(.N_IN(3), .N_OUT(2)) ia ();
   truth_table_sweeper_if #(.N_IN(3), .N_OUT(2)) ib ();
   truth_table_sweeper_if #(.N_IN(4), .N_OUT(2)) ic ();

   truth_table_sweeper #(.N_IN(3), .N_OUT(2), .DWELL(10), .GRAY(0)) u_a (
      .clk_i(clk), .reset_i(reset), .bus(ia.slave));
   truth_table_sweeper #(.N_IN(3), .N_OUT(2), .DWELL(2), .GRAY(1)) u_b (
      .clk_i(clk), .reset_i(reset), .bus(ib.slave));
   truth_table_sweeper #(.N_IN(4), .N_OUT(2), .DWELL(1), .GRAY(0)) u_c (
      .clk_i(clk), .reset_i(reset), .bus(ic.slave));

   logic [7:0] mask_a;

   always_comb begin
      ia.dut_out = {ia.vec[2] ^ ia.vec[0], ia.vec[1]};
      ia.exp_out = ia.dut_out ^ {1'b0, mask_a[ia.vec]};
      ib.dut_out = ib.vec[1:0];
      ib.exp_out = ib.vec[1:0];
      ic.dut_out = ic.vec[1:0];
      ic.exp_out = ~ic.vec[1:0];
   end

   typedef struct {
      logic [7:0] mask;
      int         cnt;
      logic       flag;
      int         first;
   } vec_t;

   vec_t tbl[6];
   int   gseq[8];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one default sweep; returns at T+81 with done expected high
   task automatic sweep_a(input logic [7:0] m, input logic hold);
      mask_a   = m;
      ia.start = 1'b1;
      step();
      if (!hold) ia.start = 1'b0;
      for (int i = 0; i < 80; i++) begin
         chk($sformatf("a_busy[%0d]", i), 32'(ia.busy), 1);
         chk($sformatf("a_vec[%0d]", i), 32'(ia.vec), i / 10);
         chk($sformatf("a_smp[%0d]", i), 32'(ia.sample),
             (i % 10 == 9) ? 1 : 0);
         step();
      end
      chk("a_done_end", 32'(ia.done), 1);
      chk("a_busy_end", 32'(ia.busy), 0);
      chk("a_smp_end", 32'(ia.sample), 0);
      chk("a_vec_end", 32'(ia.vec), 7);
   endtask

   initial begin
      int ns;
      tbl[0] = '{8'h00, 0, 1'b0, 0};
      tbl[1] = '{8'h60, 2, 1'b1, 5};
      tbl[2] = '{8'h80, 1, 1'b1, 7};
      tbl[3] = '{8'hFF, 8, 1'b1, 0};
      tbl[4] = '{8'h0A, 2, 1'b1, 1};
      tbl[5] = '{8'h01, 1, 1'b1, 0};
      gseq = '{0, 1, 3, 2, 6, 7, 5, 4};
      mask_a   = 8'h00;
      ia.start = 1'b0;
      ib.start = 1'b0;
      ic.start = 1'b0;

      repeat (3) step();
      chk("rst_a", {ia.vec, ia.sample, ia.busy, ia.done,
                    ia.err_cnt, ia.err_flag, ia.first_err}, 0);
      chk("rst_b", {ib.vec, ib.sample, ib.busy, ib.done,
                    ib.err_cnt, ib.err_flag, ib.first_err}, 0);
      chk("rst_c", {ic.vec, ic.sample, ic.busy, ic.done,
                    ic.err_cnt, ic.err_flag, ic.first_err}, 0);
      reset = 1'b0;
      step();

      for (int k = 0; k < 6; k++) begin
         sweep_a(tbl[k].mask, 1'b0);
         chk($sformatf("t%0d_cnt", k), 32'(ia.err_cnt), tbl[k].cnt);
         chk($sformatf("t%0d_flag", k), 32'(ia.err_flag), 32'(tbl[k].flag));
         chk($sformatf("t%0d_first", k), 32'(ia.first_err), tbl[k].first);
         step();
         chk($sformatf("t%0d_done_hold", k), 32'(ia.done), 1);
         chk($sformatf("t%0d_cnt_hold", k), 32'(ia.err_cnt), tbl[k].cnt);
      end

      // start held high through a whole sweep
      sweep_a(8'h04, 1'b1);
      chk("hold_cnt", 32'(ia.err_cnt), 1);
      step();
      chk("hold_restart_busy", 32'(ia.busy), 1);
      chk("hold_restart_done", 32'(ia.done), 0);
      chk("hold_restart_cnt", 32'(ia.err_cnt), 0);
      chk("hold_restart_vec", 32'(ia.vec), 0);
      ia.start = 1'b0;
      ns = 0;
      for (int i = 0; i < 80; i++) begin
         if (ia.busy) ns++;
         step();
      end
      chk("hold2_busy_cycles", 32'(ns), 80);
      chk("hold2_done", 32'(ia.done), 1);
      chk("hold2_cnt", 32'(ia.err_cnt), 1);

      // reset mid-sweep after a mismatch was counted
      mask_a   = 8'h01;
      ia.start = 1'b1;
      step();
      ia.start = 1'b0;
      repeat (34) step();
      chk("mid_cnt_pre", 32'(ia.err_cnt), 1);
      chk("mid_busy_pre", 32'(ia.busy), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst", {ia.vec, ia.sample, ia.busy, ia.done,
                      ia.err_cnt, ia.err_flag, ia.first_err}, 0);
      step();
      chk("mid_idle", {ia.busy, ia.done}, 0);
      sweep_a(8'h00, 1'b0);
      chk("post_rst_cnt", 32'(ia.err_cnt), 0);

      // Gray order, DWELL=2
      ib.start = 1'b1;
      step();
      ib.start = 1'b0;
      ns = 0;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("g_busy[%0d]", i), 32'(ib.busy), 1);
         chk($sformatf("g_vec[%0d]", i), 32'(ib.vec), gseq[i / 2]);
         chk($sformatf("g_smp[%0d]", i), 32'(ib.sample), i % 2);
         if (ib.sample) ns++;
         step();
      end
      chk("g_samples", 32'(ns), 8);
      chk("g_done", 32'(ib.done), 1);
      chk("g_busy_end", 32'(ib.busy), 0);
      chk("g_cnt", 32'(ib.err_cnt), 0);

      // DWELL=1, N_IN=4, every vector mismatching
      ic.start = 1'b1;
      step();
      ic.start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("c_smp[%0d]", i), 32'(ic.sample), 1);
         chk($sformatf("c_vec[%0d]", i), 32'(ic.vec), i);
         step();
      end
      chk("c_done", 32'(ic.done), 1);
      chk("c_cnt", 32'(ic.err_cnt), 16);
      chk("c_flag", 32'(ic.err_flag), 1);
      chk("c_first", 32'(ic.first_err), 0);
      chk("c_vec_end", 32'(ic.vec), 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Sequential, parametrised stimulus-and-check engine for small combinational blocks.
- On a start request it drives every one of the 2^N_IN input vectors in binary or Gray order.
- Each vector is held for DWELL clock cycles. Just before the vector changes, the block compares the DUT outputs against golden-model outputs.
- It counts mismatches and records the first failing vector. It sits between a combinational DUT and its golden model, and replaces hand-written fixed-delay stimulus lists.

## Interface

Parameters:
- N_IN, 3, number of DUT inputs; 2^N_IN vectors swept (1..16)
- N_OUT, 2, number of DUT outputs compared (1..32)
- DWELL, 10, clock cycles each vector is held (>=1)
- GRAY, 0, 0 = binary order, 1 = Gray-code order

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a sweep; sampled only in IDLE or DONE
- dut_out  in  N_OUT  outputs of the DUT under test
- exp_out  in  N_OUT  outputs of the golden model for the same vector
- vec  out  N_IN  stimulus vector driven to DUT and golden model
- sample  out  1  high in the compare cycle of each vector
- busy  out  1  high while sweeping
- done  out  1  high from sweep completion until next start or reset
- err_cnt  out  N_IN+1  number of mismatching vectors, range 0..2^N_IN
- err_flag  out  1  high once any mismatch has been counted in the current sweep
- first_err  out  N_IN  vec value of the first mismatch; 0 while err_flag=0

## Operation

- Three states: IDLE, RUN, DONE.
- Reset (any state, including mid-sweep) forces:
  - state IDLE;
  - vec=0, sample=0, busy=0, done=0;
  - err_cnt=0, err_flag=0, first_err=0;
  - internal index=0, dwell counter=0.
- IDLE, start=1 -> RUN. Index, dwell counter, err_cnt, err_flag and first_err are cleared.
- DONE, start=1 -> RUN, with the same clears. done drops.
- RUN behaviour:
  - vec = idx when GRAY=0; vec = idx ^ (idx>>1) when GRAY=1.
  - The dwell counter counts 0..DWELL-1.
  - sample = 1 when the dwell counter equals DWELL-1.
- In each sample cycle:
  - If dut_out != exp_out (full N_OUT-bit compare), err_cnt increments by 1.
  - On the first such mismatch, err_flag sets and first_err captures the current vec.
  - err_cnt cannot overflow, because its width holds 2^N_IN.
- After the sample cycle:
  - If idx < 2^N_IN-1, idx increments and the dwell counter returns to 0.
  - Otherwise the state goes to DONE.
- start is ignored while in RUN.
- DONE:
  - busy=0, done=1, sample=0.
  - vec holds the last vector driven.
  - err_cnt, err_flag and first_err hold their values.
- DWELL=1: sample is high on every RUN cycle and vec changes every cycle.

## Timing

- Edge T, start=1 seen in IDLE or DONE: from T+1, busy=1 and vec=first vector (0).
- Vector k is driven on cycles T+1+k*DWELL .. T+k*DWELL+DWELL. sample is high on the last of these cycles.
- Compare is combinational on dut_out/exp_out in the sample cycle. err_cnt, err_flag and first_err update on the following edge.
- Last sample cycle is T+2^N_IN*DWELL. From T+2^N_IN*DWELL+1:
  - busy=0, done=1;
  - the final err_cnt is visible in the same cycle.
- busy is high for exactly 2^N_IN*DWELL cycles.
- The DUT and golden model have DWELL-1 cycles of settling before each compare.
- reset asserted at edge R takes priority over start and over the sample update. Outputs are at reset values from R+1.

## Test plan

- Defaults (N_IN=3, N_OUT=2, DWELL=10, GRAY=0), exp_out tied to dut_out, start pulse:
  - vec steps 0..7, each held 10 cycles;
  - busy high 80 cycles;
  - done=1 at start+81, err_cnt=0, err_flag=0.
- Golden model differs from DUT only at vec=5 and vec=6:
  - err_cnt=2, err_flag=1, first_err=5 at done.
- GRAY=1, DWELL=2:
  - vec sequence 0,1,3,2,6,7,5,4, each held 2 cycles;
  - 8 sample pulses; done after 16 busy cycles.
- reset at cycle 35 of a default sweep, with a mismatch already counted:
  - next cycle all outputs 0, state IDLE.
  - A fresh start sweeps from vec=0.
- start held high throughout a sweep:
  - the sweep is not restarted; busy stays high the full 80 cycles.
  - The cycle after done rises, a new sweep begins, with err_cnt cleared at that edge.
- DWELL=1, N_IN=4, every vector mismatching:
  - sample high on 16 consecutive cycles;
  - err_cnt=16 (full-scale, no wrap), first_err=0.
